// File: rtl/filter2d_pkg.sv
// rtl/filter2d_pkg.sv - shared geometry, widths and state encoding for the 2D filter engine
package filter2d_pkg;

   localparam int PIX_W       = 8;
   localparam int WORD_W      = 32;
   localparam int IMG_W       = 256;
   localparam int IMG_H       = 256;
   localparam int FRAME_WORDS = IMG_W * IMG_H * PIX_W / WORD_W;
   localparam int ADDR_W      = 14;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word head output; push on full is
// accepted only when a pop frees the slot in the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/filter2d_out_pack.sv
// rtl/filter2d_out_pack.sv - packs the filter pixel strobe stream into 32-bit words and
// writes one frame to the output image memory through a valid/ready port
module filter2d_out_pack
   import filter2d_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              i_strb,
   input  logic [PIX_W-1:0]  i_data,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int                ENTRY_W   = WORD_W + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   state_t                    state;
   logic [1:0]                byte_cnt;
   logic [WORD_W-PIX_W-1:0]   pack_reg;
   logic [ADDR_W-1:0]         push_addr;

   logic                      accept;
   logic                      word_done;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      drop;
   logic                      frame_end;
   logic [ENTRY_W-1:0]        push_entry;
   logic [ENTRY_W-1:0]        head_entry;
   logic [ADDR_W-1:0]         head_addr;
   logic [WORD_W-1:0]         head_data;

   // A strobe coinciding with start belongs to the abandoned frame and is discarded.
   assign accept     = (state == ST_RUN) && i_strb && !start;
   assign word_done  = accept && (byte_cnt == 2'd3);
   assign push_entry = {push_addr, i_data, pack_reg};

   assign fifo_pop   = !fifo_empty && wr_ready;
   assign drop       = word_done && fifo_full && !fifo_pop;

   assign head_addr  = head_entry[ENTRY_W-1 -: ADDR_W];
   assign head_data  = head_entry[WORD_W-1:0];

   // The last word ends the frame whether it is written or lost to overflow.
   assign frame_end  = (state == ST_RUN) &&
                       ((fifo_pop && (head_addr == LAST_ADDR)) ||
                        (drop && (push_addr == LAST_ADDR)));

   assign mem_wr  = !fifo_empty;
   assign wr_addr = mem_wr ? head_addr : '0;
   assign wr_data = mem_wr ? head_data : '0;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (start),
      .push  (word_done),
      .pop   (fifo_pop),
      .din   (push_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head_entry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         byte_cnt  <= '0;
         pack_reg  <= '0;
         push_addr <= '0;
      end else if (start) begin
         state     <= ST_RUN;
         busy      <= 1'b1;
         done      <= 1'b0;
         overflow  <= 1'b0;
         byte_cnt  <= '0;
         pack_reg  <= '0;
         push_addr <= '0;
      end else begin
         done <= frame_end;
         if (frame_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end
         if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
               2'd0:    pack_reg[PIX_W-1:0]         <= i_data;
               2'd1:    pack_reg[2*PIX_W-1:PIX_W]   <= i_data;
               2'd2:    pack_reg[3*PIX_W-1:2*PIX_W] <= i_data;
               default: pack_reg                    <= pack_reg;
            endcase
         end
         // A dropped word still consumes its address so the image geometry holds.
         if (word_done) begin
            push_addr <= push_addr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_filter2d_out_pack.sv
// tb/tb_filter2d_out_pack.sv - directed self-checking bench for filter2d_out_pack
module tb_filter2d_out_pack;
   import filter2d_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              i_strb;
   logic [PIX_W-1:0]  i_data;
   logic              mem_wr;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              wr_ready;
   logic              busy;
   logic              done;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+WORD_W-1:0] wq [$];
   int   done_cnt = 0;
   logic busy_at_done = 1'b1;

   filter2d_out_pack dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .i_strb   (i_strb),
      .i_data   (i_data),
      .mem_wr   (mem_wr),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_wr && wr_ready) wq.push_back({wr_addr, wr_data});
         if (done) begin
            done_cnt++;
            busy_at_done = busy;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pix(input logic [7:0] v);
      i_strb = 1'b1;
      i_data = v;
      tick();
      i_strb = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int j = 0; j < 4; j++) pix(w[8*j +: 8]);
   endtask

   function automatic logic [31:0] wv(input logic [7:0] base, input int k);
      logic [7:0] b;
      b = base + 8'(4 * k);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   initial begin
      logic mw_seen;
      logic [31:0] w;
      int bad;
      int lows;

      reset = 1'b1; start = 1'b0; i_strb = 1'b0; i_data = '0; wr_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      mw_seen = 1'b0;
      repeat (5) begin
         tick();
         if (mem_wr) mw_seen = 1'b1;
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
      check("rst_mem_wr", mw_seen, 0);

      // First word and its latency
      wr_ready = 1'b1;
      pulse_start();
      check("start_busy", busy, 1);
      wq.delete();
      pix(8'h11); pix(8'h22); pix(8'h33);
      check("pre_mem_wr", mem_wr, 0);
      pix(8'h44);
      check("w0_mem_wr", mem_wr, 1);
      check("w0_data", wr_data, 32'h44332211);
      check("w0_addr", wr_addr, 0);
      send_word(32'h88776655);
      repeat (3) tick();
      check("w_cnt", wq.size(), 2);
      check("w1_entry", wq[1], {14'd1, 32'h88776655});
      check("w_ovf", overflow, 0);

      // Overflow: four held, fifth dropped, its address skipped
      wr_ready = 1'b0;
      pulse_start();
      wq.delete();
      for (int k = 0; k < 5; k++) send_word(wv(8'hA0, k));
      check("ovf_set", overflow, 1);
      check("ovf_head_addr", wr_addr, 0);
      check("ovf_head_data", wr_data, wv(8'hA0, 0));
      wr_ready = 1'b1;
      repeat (6) tick();
      check("ovf_drain_mem_wr", mem_wr, 0);
      check("ovf_wr_cnt", wq.size(), 4);
      for (int k = 0; k < 4; k++)
         check($sformatf("ovf_wr%0d", k), wq[k], {14'(k), wv(8'hA0, k)});
      send_word(wv(8'hA0, 5));
      repeat (3) tick();
      check("ovf_skip_cnt", wq.size(), 5);
      check("ovf_skip_entry", wq[4], {14'd5, wv(8'hA0, 5)});
      check("ovf_sticky", overflow, 1);

      // Restart mid-frame after 6 pixels, with a same-cycle strobe
      wr_ready = 1'b0;
      for (int j = 0; j < 6; j++) pix(8'hC0 + 8'(j));
      check("mid_mem_wr", mem_wr, 1);
      start = 1'b1; i_strb = 1'b1; i_data = 8'hEE;
      tick();
      start = 1'b0; i_strb = 1'b0;
      check("mid_flush", mem_wr, 0);
      check("mid_ovf_clr", overflow, 0);
      check("mid_busy", busy, 1);
      wq.delete();
      wr_ready = 1'b1;
      send_word(32'hD3D2D1D0);
      repeat (3) tick();
      check("mid_cnt", wq.size(), 1);
      check("mid_entry", wq[0], {14'd0, 32'hD3D2D1D0});

      // Push on full with simultaneous pop
      wr_ready = 1'b0;
      pulse_start();
      wq.delete();
      for (int k = 0; k < 4; k++) send_word(wv(8'h10, k));
      check("full_ovf0", overflow, 0);
      w = wv(8'h10, 4);
      pix(w[7:0]); pix(w[15:8]); pix(w[23:16]);
      i_strb = 1'b1; i_data = w[31:24]; wr_ready = 1'b1;
      tick();
      i_strb = 1'b0;
      check("full_pop_ovf", overflow, 0);
      repeat (8) tick();
      check("full_pop_cnt", wq.size(), 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("full_pop_wr%0d", k), wq[k], {14'(k), wv(8'h10, k)});

      // Full frame with throttled write port
      pulse_start();
      wq.delete();
      done_cnt = 0;
      lows = 0;
      for (int i = 0; i < 65536; i++) begin
         i_strb = 1'b1;
         i_data = i[7:0];
         wr_ready = (lows >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
         lows = wr_ready ? 0 : lows + 1;
         tick();
      end
      i_strb = 1'b0;
      wr_ready = 1'b1;
      for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
      check("frame_done_seen", done_cnt > 0, 1);
      repeat (5) tick();
      check("frame_done_once", done_cnt, 1);
      check("frame_busy_at_done", busy_at_done, 0);
      check("frame_busy_end", busy, 0);
      check("frame_ovf", overflow, 0);
      check("frame_wr_cnt", wq.size(), FRAME_WORDS);
      if (wq.size() > 0)
         check("frame_last", wq[wq.size()-1], {14'h3FFF, 32'hFFFEFDFC});
      bad = 0;
      for (int k = 0; k < wq.size(); k++)
         if (wq[k] !== {14'(k), wv(8'h00, k)}) bad++;
      check("frame_data_errs", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
